// File: rtl/dvp_tx_pkg.sv
// Shared types and helpers for the OV5640-style DVP transmitter:
// FSM state encoding, bytes-per-pixel derivation, byte packing and
// the colour-bar palette used by the optional test-pattern generator.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } dvp_state_t;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // RGB565 needs two byte slots per pixel, RGB888 three.
  function automatic int bpp_of(input int rgb_type);
    return (rgb_type == 1) ? 3 : 2;
  endfunction

  // Select the byte for a given slot of an {R,G,B} pixel.
  function automatic logic [7:0] pack_byte(input logic [23:0] rgb,
                                           input int          rgb_type,
                                           input logic [1:0]  slot);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = rgb[23:16];
    g = rgb[15:8];
    b = rgb[7:0];
    pack_byte = 8'h00;
    if (rgb_type == 1) begin
      case (slot)
        2'd0:    pack_byte = r;
        2'd1:    pack_byte = g;
        2'd2:    pack_byte = b;
        default: pack_byte = 8'h00;
      endcase
    end else begin
      case (slot)
        2'd0:    pack_byte = {r[7:3], g[7:5]};
        2'd1:    pack_byte = {g[4:2], b[7:3]};
        default: pack_byte = 8'h00;
      endcase
    end
  endfunction

  // Classic 8-bar order, left to right.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// Frame timing for the DVP transmitter: horizontal/vertical counters and
// the IDLE/VSYNC/VBP/ACTIVE/VFP state machine. Produces href, vsync, the
// byte slot within the current pixel, the pixel column, a frame-done pulse
// and a look-ahead flag marking the cycle before each pixel's first byte.
module dvp_tx_timing
  import dvp_tx_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 720,
  parameter int BPP          = 2,
  parameter int H_BLANK      = 1290,
  parameter int VS_LINES     = 4,
  parameter int V_BP_LINES   = 16,
  parameter int V_FP_LINES   = 240,
  parameter int CNT_W        = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             href,
  output logic             vsync,
  output logic [1:0]       slot,
  output logic [CNT_W-1:0] col,
  output logic             frame_done,
  output logic             pix_slot_next
);

  localparam int LP    = IMAGE_WIDTH * BPP + H_BLANK;
  localparam int MAX_A = (VS_LINES > V_BP_LINES) ? VS_LINES : V_BP_LINES;
  localparam int MAX_B = (IMAGE_HEIGHT > V_FP_LINES) ? IMAGE_HEIGHT : V_FP_LINES;
  localparam int MAX_L = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int V_W   = $clog2(MAX_L + 1);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(LP - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(IMAGE_WIDTH * BPP);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(IMAGE_WIDTH * BPP - 1);
  localparam logic [V_W-1:0]   V_LAST_ACT = V_W'(IMAGE_HEIGHT - 1);
  localparam logic [1:0]       B_LAST   = 2'(BPP - 1);

  // Zero-length blanking states are skipped when choosing successors.
  localparam dvp_state_t FIRST_STATE = (VS_LINES > 0)   ? ST_VSYNC :
                                       (V_BP_LINES > 0) ? ST_VBP : ST_ACTIVE;
  localparam dvp_state_t AFTER_VS    = (V_BP_LINES > 0) ? ST_VBP : ST_ACTIVE;

  dvp_state_t       state, nxt_state, restart;
  logic [CNT_W-1:0] h_cnt, nxt_h;
  logic [CNT_W-1:0] col_cnt, nxt_col;
  logic [V_W-1:0]   v_cnt, nxt_v, v_last;
  logic [1:0]       b_cnt, nxt_b;
  logic             fd_q;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
      b_cnt   <= '0;
      col_cnt <= '0;
    end else begin
      state   <= nxt_state;
      h_cnt   <= nxt_h;
      v_cnt   <= nxt_v;
      b_cnt   <= nxt_b;
      col_cnt <= nxt_col;
    end
  end

  // Next-state and counter advance; enable only matters at frame boundaries.
  always_comb begin
    nxt_state = state;
    nxt_h     = h_cnt;
    nxt_v     = v_cnt;
    nxt_b     = b_cnt;
    nxt_col   = col_cnt;
    restart   = enable ? FIRST_STATE : ST_IDLE;
    v_last    = '0;
    case (state)
      ST_VSYNC:  v_last = V_W'(VS_LINES - 1);
      ST_VBP:    v_last = V_W'(V_BP_LINES - 1);
      ST_ACTIVE: v_last = V_LAST_ACT;
      ST_VFP:    v_last = V_W'(V_FP_LINES - 1);
      default:   v_last = '0;
    endcase
    if (state == ST_IDLE) begin
      nxt_h   = '0;
      nxt_v   = '0;
      nxt_b   = '0;
      nxt_col = '0;
      if (enable) nxt_state = FIRST_STATE;
    end else if (h_cnt == H_LAST) begin
      nxt_h   = '0;
      nxt_b   = '0;
      nxt_col = '0;
      if (v_cnt == v_last) begin
        nxt_v = '0;
        case (state)
          ST_VSYNC:  nxt_state = AFTER_VS;
          ST_VBP:    nxt_state = ST_ACTIVE;
          ST_ACTIVE: nxt_state = (V_FP_LINES > 0) ? ST_VFP : restart;
          default:   nxt_state = restart;
        endcase
      end else begin
        nxt_v = v_cnt + 1'b1;
      end
    end else begin
      nxt_h = h_cnt + 1'b1;
      if (b_cnt == B_LAST) begin
        nxt_b   = '0;
        nxt_col = col_cnt + 1'b1;
      end else begin
        nxt_b = b_cnt + 1'b1;
      end
    end
  end

  // Frame-done flag: registered so it lands one cycle after the last active byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fd_q <= 1'b0;
    else        fd_q <= (state == ST_ACTIVE) && (v_cnt == V_LAST_ACT) && (h_cnt == ACT_LAST);
  end

  assign href          = (state == ST_ACTIVE) && (h_cnt < ACT_END);
  assign vsync         = (state == ST_VSYNC);
  assign slot          = b_cnt;
  assign col           = col_cnt;
  assign frame_done    = fd_q;
  assign pix_slot_next = (nxt_state == ST_ACTIVE) && (nxt_h < ACT_END) && (nxt_b == 2'd0);

endmodule

// File: rtl/ov5640_dvp_tx.sv
// OV5640-style DVP transmitter: accepts {R,G,B} pixels on a valid/ready
// stream and serialises them as RGB565 or RGB888 bytes with vsync/href
// framing. Optional feature macro: DVP_TX_TEST_PATTERN_EN adds an 8-bar
// colour generator selected by tp_en_i.
module ov5640_dvp_tx
  import dvp_tx_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 720,
  parameter int RGB_TYPE     = 0,
  parameter int H_BLANK      = 1290,
  parameter int VS_LINES     = 4,
  parameter int V_BP_LINES   = 16,
  parameter int V_FP_LINES   = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic [23:0] pix_rgb_i,
  input  logic        pix_sof_i,
  input  logic        tp_en_i,
  output logic        cmos_vsync_o,
  output logic        cmos_href_o,
  output logic [7:0]  cmos_data_o,
  output logic        frame_done_o,
  output logic        underflow_o,
  output logic        sof_err_o
);

  localparam int BPP   = bpp_of(RGB_TYPE);
  localparam int LP    = IMAGE_WIDTH * BPP + H_BLANK;
  localparam int CNT_W = $clog2(LP + 1);

  logic             href, vsync, frame_done, pix_slot_next;
  logic [1:0]       slot;
  logic [CNT_W-1:0] col;
  logic             tp_mode, take, accept;
  logic [23:0]      pix_rgb_p1;
  logic             vld_p1;
  logic             sof_pending;
  logic [7:0]       byte_val;

  dvp_tx_timing #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT),
    .BPP          (BPP),
    .H_BLANK      (H_BLANK),
    .VS_LINES     (VS_LINES),
    .V_BP_LINES   (V_BP_LINES),
    .V_FP_LINES   (V_FP_LINES),
    .CNT_W        (CNT_W)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable_i),
    .href          (href),
    .vsync         (vsync),
    .slot          (slot),
    .col           (col),
    .frame_done    (frame_done),
    .pix_slot_next (pix_slot_next)
  );

`ifdef DVP_TX_TEST_PATTERN_EN
  localparam int BAR_W = (IMAGE_WIDTH / 8 > 0) ? IMAGE_WIDTH / 8 : 1;
  int         bar_div;
  logic [2:0] bar_idx;

  assign tp_mode = tp_en_i;

  // Map pixel column to a bar; the last bar absorbs any remainder.
  always_comb begin
    bar_div = 32'(col) / BAR_W;
    bar_idx = (bar_div > 7) ? 3'd7 : 3'(bar_div);
  end
`else
  logic unused_tp;
  logic unused_col;
  assign tp_mode    = 1'b0;
  assign unused_tp  = tp_en_i;
  assign unused_col = ^col;
`endif

  // A pixel slot is offered one cycle before its first byte goes out.
  assign take        = pix_slot_next && !tp_mode;
  assign accept      = take && pix_valid_i;
  assign pix_ready_o = take;

  // ---- stage p1: pixel held for the duration of its byte slots ----
  always_ff @(posedge clk) begin
    if (take) pix_rgb_p1 <= pix_rgb_i;
  end

  // Valid travels with the held pixel; a missing pixel is sent as zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    vld_p1 <= 1'b0;
    else if (take) vld_p1 <= pix_valid_i;
  end

  // Sticky underflow / SOF-alignment flags; no resync on SOF error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_o <= 1'b0;
      sof_err_o   <= 1'b0;
      sof_pending <= 1'b1;
    end else begin
      if (take && !pix_valid_i)                    underflow_o <= 1'b1;
      if (accept && (pix_sof_i != sof_pending))    sof_err_o   <= 1'b1;
      if (frame_done)  sof_pending <= 1'b1;
      else if (accept) sof_pending <= 1'b0;
    end
  end

  // Byte selection; bus is forced to zero outside href.
  always_comb begin
    byte_val = vld_p1 ? pack_byte(pix_rgb_p1, RGB_TYPE, slot) : 8'h00;
`ifdef DVP_TX_TEST_PATTERN_EN
    if (tp_mode) byte_val = pack_byte(bar_color(bar_idx), RGB_TYPE, slot);
`endif
    cmos_data_o = href ? byte_val : 8'h00;
  end

  assign cmos_vsync_o = vsync;
  assign cmos_href_o  = href;
  assign frame_done_o = frame_done;

endmodule
